// File: rtl/digit_counter_pkg.sv
// Shared types and helpers for the multi-digit up/down counter.
package digit_counter_pkg;

    localparam int unsigned NIB_W = 4;

    typedef logic [NIB_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Clamp a nibble to the largest legal digit value for the given radix.
    function automatic nibble_t sat_nibble(input nibble_t v, input int unsigned modulo);
        if (32'(v) >= modulo) begin
            return NIB_W'(modulo - 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/digit_counter_if.sv
// Control and display bus between the board logic and the digit counter.
interface digit_counter_if
    import digit_counter_pkg::*;
#(
    parameter int unsigned NDIG = 4
);
    logic                    start_stop;
    logic                    clear;
    logic                    up;
    logic                    load;
    logic [NIB_W*NDIG-1:0]   load_val;
    logic [NIB_W*NDIG-1:0]   digits;
    logic                    running;
    logic                    wrap;

    modport master (
        output start_stop, clear, up, load, load_val,
        input  digits, running, wrap
    );

    modport slave (
        input  start_stop, clear, up, load, load_val,
        output digits, running, wrap
    );
endinterface

// File: rtl/digit_counter_bcd_digit.sv
// One radix-MODULO digit of the counter chain with clear, saturating load and carry/borrow.
module digit_counter_bcd_digit
    import digit_counter_pkg::*;
#(
    parameter int unsigned MODULO = 10
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_en,
    input  logic    i_up,
    input  logic    i_load,
    input  nibble_t i_ld_val,
    input  logic    i_clr,
    output nibble_t o_digit,
    output logic    o_carry_c
);
    localparam nibble_t DIG_TOP = NIB_W'(MODULO - 1);

    nibble_t r_digit;

    // Carry/borrow out when this digit is about to roll over in the current direction.
    assign o_carry_c = i_en & (i_up ? (r_digit == DIG_TOP) : (r_digit == '0));
    assign o_digit   = r_digit;

    // Digit register: clear beats load beats count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_digit <= '0;
        end else if (i_clr) begin
            r_digit <= '0;
        end else if (i_load) begin
            r_digit <= sat_nibble(i_ld_val, MODULO);
        end else if (i_en) begin
            if (i_up) begin
                r_digit <= (r_digit == DIG_TOP) ? '0 : r_digit + NIB_W'(1);
            end else begin
                r_digit <= (r_digit == '0) ? DIG_TOP : r_digit - NIB_W'(1);
            end
        end
    end

endmodule

// File: rtl/digit_counter.sv
// Multi-digit up/down stopwatch counter with run/pause FSM and tick prescaler.
module digit_counter
    import digit_counter_pkg::*;
#(
    parameter int unsigned CLK_DIV = 500000,
    parameter int unsigned NDIG    = 4,
    parameter int unsigned MODULO  = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    digit_counter_if.slave bus
);
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic          r_ss_prev;
    logic          r_running;
    logic          r_wrap;

    logic          w_edge;
    logic          w_tick;
    logic [NDIG:0] w_en;
    nibble_t       w_digit [NDIG];

    assign w_edge = bus.start_stop & ~r_ss_prev;
    assign w_tick = (r_state == RUN) && (r_presc == PRESC_LAST);

    // Clear and load both discard a pending tick, so the chain never counts or wraps with them.
    assign w_en[0] = w_tick & ~bus.clear & ~bus.load;

    // Ripple chain: each digit is enabled by the carry/borrow of the one below it.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        digit_counter_bcd_digit #(
            .MODULO (MODULO)
        ) u_digit (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (w_en[gi]),
            .i_up      (bus.up),
            .i_load    (bus.load),
            .i_ld_val  (bus.load_val[NIB_W*gi +: NIB_W]),
            .i_clr     (bus.clear),
            .o_digit   (w_digit[gi]),
            .o_carry_c (w_en[gi+1])
        );
        assign bus.digits[NIB_W*gi +: NIB_W] = w_digit[gi];
    end

    assign bus.running = r_running;
    assign bus.wrap    = r_wrap;

    // Control FSM, prescaler, StartStop edge register and registered status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_ss_prev <= 1'b0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_ss_prev <= bus.start_stop;
            r_wrap    <= 1'b0;
            if (bus.clear) begin
                r_state   <= IDLE;
                r_presc   <= '0;
                r_running <= 1'b0;
            end else begin
                if (bus.load) begin
                    r_presc <= '0;
                end else if (r_state == RUN) begin
                    r_presc <= w_tick ? '0 : r_presc + PW'(1);
                end
                r_wrap <= w_en[NDIG];
                if (w_edge) begin
                    case (r_state)
                        IDLE, PAUSE: begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                        RUN: begin
                            r_state   <= PAUSE;
                            r_running <= 1'b0;
                        end
                        default: begin
                            r_state   <= IDLE;
                            r_running <= 1'b0;
                        end
                    endcase
                end else if (bus.load && (r_state == IDLE)) begin
                    r_state   <= PAUSE;
                    r_running <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_counter.sv
// Directed self-checking bench for digit_counter (BCD and hex instances).
module tb_digit_counter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    digit_counter_if #(.NDIG(4)) if_a ();
    digit_counter_if #(.NDIG(4)) if_b ();

    digit_counter #(.CLK_DIV(4), .NDIG(4), .MODULO(10)) dut_bcd (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_a)
    );

    digit_counter #(.CLK_DIV(4), .NDIG(4), .MODULO(16)) dut_hex (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_b)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        errors = 0;
        checks = 0;
        if_a.start_stop = 1'b0; if_a.clear = 1'b0; if_a.up = 1'b0;
        if_a.load = 1'b0; if_a.load_val = '0;
        if_b.start_stop = 1'b0; if_b.clear = 1'b0; if_b.up = 1'b0;
        if_b.load = 1'b0; if_b.load_val = '0;

        // Reset state
        step(2);
        check("rst_digits", 32'(if_a.digits), 32'h0);
        check("rst_running", 32'(if_a.running), 32'h0);
        check("rst_wrap", 32'(if_a.wrap), 32'h0);
        rst = 1'b0;
        step(1);

        // Start counting up from zero
        if_a.up = 1'b1;
        if_a.start_stop = 1'b1;
        step(1);
        check("start_running", 32'(if_a.running), 32'h1);
        if_a.start_stop = 1'b0;
        step(3);
        check("pre_first_tick", 32'(if_a.digits), 32'h0000);
        step(1);
        check("first_tick", 32'(if_a.digits), 32'h0001);
        step(36);
        check("tenth_tick", 32'(if_a.digits), 32'h0010);
        check("no_wrap_carry", 32'(if_a.wrap), 32'h0);

        // Pause two cycles into a period, hold, then resume
        step(1);
        if_a.start_stop = 1'b1;
        step(1);
        check("pause_running", 32'(if_a.running), 32'h0);
        if_a.start_stop = 1'b0;
        step(20);
        check("pause_frozen", 32'(if_a.digits), 32'h0010);
        if_a.start_stop = 1'b1;
        step(1);
        check("resume_running", 32'(if_a.running), 32'h1);
        if_a.start_stop = 1'b0;
        step(1);
        check("resume_hold", 32'(if_a.digits), 32'h0010);
        step(1);
        check("resume_tick", 32'(if_a.digits), 32'h0011);

        // Clear with a StartStop edge in the same cycle
        if_a.clear = 1'b1;
        if_a.start_stop = 1'b1;
        step(1);
        if_a.clear = 1'b0;
        if_a.start_stop = 1'b0;
        check("clr_edge_digits", 32'(if_a.digits), 32'h0000);
        check("clr_edge_running", 32'(if_a.running), 32'h0);

        // Saturating load from IDLE
        if_a.load = 1'b1;
        if_a.load_val = 16'hFA37;
        step(1);
        if_a.load = 1'b0;
        check("load_sat", 32'(if_a.digits), 32'h9937);
        check("load_idle_paused", 32'(if_a.running), 32'h0);

        // Up wrap 9999 -> 0000
        if_a.load = 1'b1;
        if_a.load_val = 16'h9998;
        step(1);
        if_a.load = 1'b0;
        if_a.start_stop = 1'b1;
        step(1);
        if_a.start_stop = 1'b0;
        step(4);
        check("up_9999", 32'(if_a.digits), 32'h9999);
        check("up_9999_nowrap", 32'(if_a.wrap), 32'h0);
        step(3);
        check("up_hold_9999", 32'(if_a.digits), 32'h9999);
        step(1);
        check("up_wrap_digits", 32'(if_a.digits), 32'h0000);
        check("up_wrap_pulse", 32'(if_a.wrap), 32'h1);
        check("up_wrap_running", 32'(if_a.running), 32'h1);
        step(1);
        check("up_wrap_one_cycle", 32'(if_a.wrap), 32'h0);

        // Down wrap 0000 -> 9999 -> 9998
        if_a.clear = 1'b1;
        step(1);
        if_a.clear = 1'b0;
        if_a.up = 1'b0;
        if_a.start_stop = 1'b1;
        step(1);
        if_a.start_stop = 1'b0;
        step(3);
        check("down_pre", 32'(if_a.digits), 32'h0000);
        step(1);
        check("down_wrap_digits", 32'(if_a.digits), 32'h9999);
        check("down_wrap_pulse", 32'(if_a.wrap), 32'h1);
        step(1);
        check("down_wrap_one_cycle", 32'(if_a.wrap), 32'h0);
        step(3);
        check("down_borrow", 32'(if_a.digits), 32'h9998);

        // Load coincident with a tick that would otherwise wrap down
        if_a.load = 1'b1;
        if_a.load_val = 16'h0000;
        step(1);
        if_a.load = 1'b0;
        step(3);
        if_a.load = 1'b1;
        if_a.load_val = 16'h4321;
        step(1);
        if_a.load = 1'b0;
        check("load_tick_digits", 32'(if_a.digits), 32'h4321);
        check("load_tick_nowrap", 32'(if_a.wrap), 32'h0);
        check("load_tick_running", 32'(if_a.running), 32'h1);

        // Load with edge in RUN: both apply
        if_a.load = 1'b1;
        if_a.load_val = 16'h0555;
        if_a.start_stop = 1'b1;
        step(1);
        if_a.load = 1'b0;
        if_a.start_stop = 1'b0;
        check("load_edge_digits", 32'(if_a.digits), 32'h0555);
        check("load_edge_running", 32'(if_a.running), 32'h0);

        // Asynchronous reset between clock edges
        step(1);
        if_a.start_stop = 1'b1;
        step(1);
        if_a.start_stop = 1'b0;
        if_a.load = 1'b1;
        if_a.load_val = 16'h1234;
        step(1);
        if_a.load = 1'b0;
        check("pre_rst_digits", 32'(if_a.digits), 32'h1234);
        check("pre_rst_running", 32'(if_a.running), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_digits", 32'(if_a.digits), 32'h0);
        check("async_rst_running", 32'(if_a.running), 32'h0);
        step(1);
        rst = 1'b0;
        step(1);
        check("post_rst_idle", 32'(if_a.running), 32'h0);
        if_a.start_stop = 1'b1;
        step(1);
        if_a.start_stop = 1'b0;
        check("post_rst_restart", 32'(if_a.running), 32'h1);

        // Hex variant: FFFF counting up wraps to 0000
        if_b.load = 1'b1;
        if_b.load_val = 16'hFFFF;
        step(1);
        if_b.load = 1'b0;
        check("hex_load", 32'(if_b.digits), 32'hFFFF);
        if_b.up = 1'b1;
        if_b.start_stop = 1'b1;
        step(1);
        if_b.start_stop = 1'b0;
        check("hex_running", 32'(if_b.running), 32'h1);
        step(3);
        check("hex_hold", 32'(if_b.digits), 32'hFFFF);
        step(1);
        check("hex_wrap_digits", 32'(if_b.digits), 32'h0000);
        check("hex_wrap_pulse", 32'(if_b.wrap), 32'h1);
        step(1);
        check("hex_wrap_one_cycle", 32'(if_b.wrap), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digit_counter.md
Name: digit_counter

Overview:
- Multi-digit up/down counter with a run/pause control FSM and a clock prescaler.
- Feeds the per-digit 4-bit nibbles to the seven-segment decoder stage, one nibble per display digit.
- Used as a stopwatch/event counter on the lab board.
- Output digits are plain binary nibbles. Segment encoding and polarity belong to the downstream decoder.

Parameters:
- CLK_DIV, 500000: clock cycles per count tick; must be >= 2. Default gives 100 Hz at 50 MHz.
- NDIG, 4: number of digits, 1..8.
- MODULO, 10: per-digit radix, 2..16. Use 10 for BCD and 16 for hex.

Ports:
- Clock  in  1  system clock; all state on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- StartStop  in  1  synchronous level from the debounced button. Each rising edge toggles run/pause.
- Clear  in  1  synchronous clear.
- Up  in  1  count direction: 1 = up, 0 = down. Sampled at each tick.
- Load  in  1  synchronous parallel load.
- LoadVal  in  4*NDIG  load value; digit i is bits [4i+3:4i].
- Digits  out  4*NDIG  current count; digit 0 is least significant.
- Running  out  1  high while the FSM is in RUN.
- Wrap  out  1  one-cycle pulse when the count wraps.

Behaviour:
- One clock. Reset is asynchronous and active-high. Every other control input is synchronous.
- Reset values:
  - Digits = 0, Running = 0, Wrap = 0.
  - state = IDLE, prescaler = 0, StartStop edge register = 0.
- Edge detect:
  - The edge register holds the previous StartStop value.
  - edge = StartStop & ~prev.
  - A state change takes effect at the clock edge that samples the rising StartStop level. No extra synchroniser stage.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE --edge--> RUN
  - RUN --edge--> PAUSE
  - PAUSE --edge--> RUN
  - Clear in any state -> IDLE.
  - Load in IDLE -> PAUSE. Load in RUN or PAUSE leaves the state unchanged.
- Running = (state == RUN), registered.
- Prescaler:
  - Counts 0..CLK_DIV-1 only in RUN and holds its value in PAUSE.
  - tick = RUN && prescaler == CLK_DIV-1; the prescaler returns to 0 on a tick.
  - After RUN is entered from IDLE, the first count change occurs CLK_DIV cycles later.
- Counting on tick:
  - Up: digit 0 increments. A digit at MODULO-1 goes to 0 and carries into the next digit.
  - Down: digit 0 decrements. A digit at 0 goes to MODULO-1 and borrows from the next digit.
  - Ripple resolves combinationally within one cycle.
- Wrap:
  - Up from all digits = MODULO-1 gives all zeros.
  - Down from all zeros gives all digits = MODULO-1.
  - Wrap is high for exactly the cycle after that tick, i.e. registered alongside Digits. The FSM stays in RUN.
- Clear: Digits = 0, prescaler = 0, state = IDLE, Wrap = 0 next cycle.
- Load:
  - Digits = LoadVal and prescaler = 0.
  - Any LoadVal nibble >= MODULO is loaded as MODULO-1, per digit.
- Priority (highest first): Reset > Clear > Load > edge/tick.
  - Clear with edge in the same cycle: edge discarded, ends in IDLE.
  - Load with tick: tick discarded, no Wrap.
  - Load with edge: both take effect (state transition per edge, value from Load).
  - Tick with edge in RUN: count updates and the state goes to PAUSE in the same cycle.
- Up changing mid-run affects only subsequent ticks.
- Reset asserted mid-count returns everything to reset values immediately and asynchronously. After deassertion the block restarts cleanly in IDLE.
- Digits are always valid nibbles < MODULO, so the downstream decoder never sees codes >= MODULO.

Decomposition:
- Package digit_counter_pkg:
  - typedef nibble_t (logic [3:0]).
  - state enum (IDLE, RUN, PAUSE).
  - Function saturating a nibble to MODULO-1.
- Sub-module bcd_digit:
  - One radix-MODULO digit register.
  - Inputs: en, up, load, ld_val, clr.
  - Outputs: carry/borrow, which is high when en and the digit is at its terminal value for the direction.
- The top instantiates NDIG bcd_digit in a generate chain. Each digit's en = tick AND all lower carries.

Test Plan (CLK_DIV=4, NDIG=4, MODULO=10 unless stated):
- Reset then StartStop pulse, Up=1:
  - Running=1 on the next cycle.
  - Digits=0x0001 after 4 cycles and 0x0010 after 40 cycles.
- Load 0x9998, Up=1, start:
  - Digits goes 9999 -> 0000.
  - Wrap high for exactly one cycle, coincident with 0000; Running stays 1.
- From 0000 with Up=0, start:
  - First tick gives 9999 with a one-cycle Wrap pulse.
  - Next tick gives 9998.
- Pause mid-period: stop 2 cycles into a period, wait 20 cycles, restart.
  - Digits frozen during the pause.
  - Next increment 2 cycles after restart (prescaler held).
- Collisions:
  - Clear and StartStop edge in the same cycle ends in IDLE with Digits=0, Running=0.
  - Load 0xFA37 gives 0x9937 (saturation).
  - Load coincident with a tick: no Wrap, Digits=LoadVal.
- Reset asserted between clock edges while Digits=0x1234:
  - Digits=0 and Running=0 before the next clock edge.
- MODULO=16 variant: from 0xFFFF counting up gives 0x0000 with Wrap.
